// File: rtl/instruction_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: opcode constants, the
// fetch FSM state encoding, the queue entry layout and the static
// next-PC predictor used when an instruction is accepted from the cache.
package instruction_fetcher_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic {
        ST_IDLE = 1'b0,   // no outstanding request
        ST_WAIT = 1'b1    // request to cache outstanding at pc
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred_pc;
    } iq_entry_t;

    localparam int IQ_ENTRY_W = $bits(iq_entry_t);

    // Static prediction: JAL always taken, backward branches taken,
    // forward branches and everything else (JALR included) fall through.
    function automatic logic [31:0] predict_next_pc(input logic [31:0] inst,
                                                    input logic [31:0] pc);
        logic [31:0] j_imm;
        logic [31:0] b_imm;
        j_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        b_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        predict_next_pc = pc + 32'd4;
        case (inst[6:0])
            OPC_JAL:    predict_next_pc = pc + j_imm;
            OPC_BRANCH: if (b_imm[31]) predict_next_pc = pc + b_imm;
            OPC_JALR:   predict_next_pc = pc + 32'd4; // target is register-dependent
            default:    ;
        endcase
    endfunction

endpackage

// File: rtl/instruction_fetcher_if.sv
// Bus bundle between the instruction fetcher and its environment
// (instruction cache, reorder buffer redirect, decoder queue port).
//   RoB_clear/RoB_pc      : flush and redirect target
//   i_waiting/i_addr      : fetch request to the cache
//   i_result/i_m_ready    : cache response; i_m_ready may rise in the same
//                           cycle as i_waiting
//   iq_empty/iq_inst/iq_pc/iq_pred_pc/iq_pop : queue head to the decoder
// Handshake: a fetch completes in every rising edge at which i_waiting=1 and
// i_m_ready=1 (with rdy_in=1 and no RoB_clear); the head entry is consumed
// at every rising edge where iq_pop=1 and iq_empty=0.
// master = fetcher side, slave = environment side.
interface instruction_fetcher_if;
    logic        RoB_clear;
    logic [31:0] RoB_pc;
    logic        i_waiting;
    logic [31:0] i_addr;
    logic [31:0] i_result;
    logic        i_m_ready;
    logic        iq_empty;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic [31:0] iq_pred_pc;
    logic        iq_pop;

    modport master (
        input  RoB_clear, RoB_pc, i_result, i_m_ready, iq_pop,
        output i_waiting, i_addr, iq_empty, iq_inst, iq_pc, iq_pred_pc
    );

    modport slave (
        output RoB_clear, RoB_pc, i_result, i_m_ready, iq_pop,
        input  i_waiting, i_addr, iq_empty, iq_inst, iq_pc, iq_pred_pc
    );
endinterface

// File: rtl/instruction_fetcher_inst_queue.sv
// inst_queue: circular FIFO of 2^DEPTH_BIT entries with synchronous clear.
// Ports: clk_in/rst_in (async active-low), en_i (global ready, freezes all
// state when low), clear_i (empties the queue, wins over push/pop), push_i,
// pop_i, din_i, dout_o (head entry, zero when empty), full_o, empty_o,
// count_o (DEPTH_BIT+1 bits so full and empty are distinguishable).
module inst_queue #(
    parameter int DEPTH_BIT = 2,
    parameter int WIDTH     = 96
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 en_i,
    input  logic                 clear_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [WIDTH-1:0]     din_i,
    output logic [WIDTH-1:0]     dout_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [DEPTH_BIT:0]   count_o
);
    localparam int DEPTH = 1 << DEPTH_BIT;
    localparam logic [DEPTH_BIT:0] DEPTH_CNT = (DEPTH_BIT + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [DEPTH_BIT-1:0] head_q, head_d, tail_q, tail_d;
    logic [DEPTH_BIT:0]   count_q, count_d;
    logic                 push_ok, pop_ok;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // Zero when empty so stale storage never leaks onto the head outputs.
    assign dout_o  = empty_o ? '0 : mem_q[head_q];

    assign push_ok = en_i && !clear_i && push_i && !full_o;
    assign pop_ok  = en_i && !clear_i && pop_i && !empty_o;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (en_i && clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) tail_d = tail_q + 1'b1;
            if (pop_ok)  head_d = head_q + 1'b1;
            count_d = count_q + {{DEPTH_BIT{1'b0}}, push_ok}
                              - {{DEPTH_BIT{1'b0}}, pop_ok};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) mem_q[tail_q] <= din_i;
    end
endmodule

// File: rtl/instruction_fetcher.sv
// instruction_fetcher: issues sequential/predicted fetch requests to the
// instruction cache and buffers returned instructions with their PC and
// predicted next PC in an inst_queue for the decoder.
// Ports: clk_in, rst_in (async active-low), rdy_in (low freezes everything),
// bus (instruction_fetcher_if.master: redirect, cache and queue-head
// signals), dbg_state_o (current fetch FSM state).
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int          IQ_DEPTH_BIT = 2,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    instruction_fetcher_if.master  bus,
    output fetch_state_e           dbg_state_o
);
    localparam logic [IQ_DEPTH_BIT:0] DEPTH_CNT = (IQ_DEPTH_BIT + 1)'(1 << IQ_DEPTH_BIT);

    fetch_state_e          state_q, state_d;
    logic [31:0]           pc_q, pc_d;
    logic [31:0]           pred_pc;
    logic                  accept, pop_hit;
    logic                  q_full, q_empty;
    logic [IQ_DEPTH_BIT:0] q_count, post_count;
    iq_entry_t             push_entry, head_entry;

    assign pred_pc = predict_next_pc(bus.i_result, pc_q);

    // In WAIT the queue is never full, so the extra full term only matters
    // as a guard: no request is ever shown while there is no room.
    assign bus.i_waiting = (state_q == ST_WAIT) && !q_full;
    assign bus.i_addr    = pc_q;
    assign dbg_state_o   = state_q;

    assign accept  = rdy_in && !bus.RoB_clear && bus.i_waiting && bus.i_m_ready;
    assign pop_hit = rdy_in && !bus.RoB_clear && bus.iq_pop && !q_empty;
    // Occupancy after this edge if the current response is accepted.
    assign post_count = q_count + {{IQ_DEPTH_BIT{1'b0}}, 1'b1}
                                - {{IQ_DEPTH_BIT{1'b0}}, pop_hit};

    assign push_entry = '{inst: bus.i_result, pc: pc_q, pred_pc: pred_pc};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (rdy_in) begin
            if (bus.RoB_clear) begin
                state_d = ST_IDLE;
                pc_d    = bus.RoB_pc;
            end else begin
                case (state_q)
                    ST_IDLE: if (!q_full) state_d = ST_WAIT;
                    ST_WAIT: if (accept) begin
                        pc_d    = pred_pc;
                        state_d = (post_count < DEPTH_CNT) ? ST_WAIT : ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    inst_queue #(
        .DEPTH_BIT (IQ_DEPTH_BIT),
        .WIDTH     (IQ_ENTRY_W)
    ) u_inst_queue (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .en_i    (rdy_in),
        .clear_i (bus.RoB_clear),
        .push_i  (accept),
        .pop_i   (bus.iq_pop),
        .din_i   (push_entry),
        .dout_o  (head_entry),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    assign bus.iq_empty   = q_empty;
    assign bus.iq_inst    = head_entry.inst;
    assign bus.iq_pc      = head_entry.pc;
    assign bus.iq_pred_pc = head_entry.pred_pc;
endmodule

// File: tb/tb_instruction_fetcher.sv
module tb_instruction_fetcher;
    import instruction_fetcher_pkg::*;

    localparam int          D    = 4;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] JAL8 = 32'h0080_006F;
    localparam logic [31:0] BEQM = 32'hFE00_0EE3;
    localparam logic [31:0] BEQP = 32'h0000_0463;
    localparam logic [31:0] JALR = 32'h0000_80E7;

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;
    fetch_state_e dbg_state;

    always #5 clk_in = ~clk_in;

    instruction_fetcher_if bus ();

    instruction_fetcher #(
        .IQ_DEPTH_BIT (2),
        .RESET_PC     (32'h0)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Entries packed as {inst, pc, pred}.
    logic [95:0] exp_q[$];
    logic [31:0] m_pc;
    bit          m_req;

    function automatic logic [31:0] ref_pred(input logic [31:0] inst, input logic [31:0] pc);
        int j;
        int b;
        j = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048 + int'(inst[19:12]) * 4096
            - (inst[31] ? 1048576 : 0);
        b = int'(inst[11:8]) * 2 + int'(inst[30:25]) * 32 + int'(inst[7]) * 2048
            - (inst[31] ? 4096 : 0);
        if (inst[6:0] == 7'h6F) return pc + 32'(j);
        if (inst[6:0] == 7'h63 && b < 0) return pc + 32'(b);
        return pc + 32'd4;
    endfunction

    task automatic model_step(input bit rdy, input bit clr, input logic [31:0] rpc,
                              input bit mr, input logic [31:0] res, input bit pop);
        int sz;
        logic [31:0] p;
        if (!rdy) return;
        if (clr) begin
            exp_q.delete();
            m_pc  = rpc;
            m_req = 1'b0;
            return;
        end
        sz = exp_q.size();
        if (pop && sz > 0) void'(exp_q.pop_front());
        if (m_req && mr) begin
            p = ref_pred(res, m_pc);
            exp_q.push_back({res, m_pc, p});
            m_pc  = p;
            m_req = (exp_q.size() < D);
        end else if (!m_req) begin
            m_req = (sz < D);
        end
    endtask

    task automatic check_model();
        logic [95:0] h;
        h = (exp_q.size() > 0) ? exp_q[0] : '0;
        chk("i_waiting", 32'(bus.i_waiting), 32'(m_req));
        chk("i_addr", bus.i_addr, m_pc);
        chk("iq_empty", 32'(bus.iq_empty), 32'(exp_q.size() == 0));
        chk("iq_inst", bus.iq_inst, h[95:64]);
        chk("iq_pc", bus.iq_pc, h[63:32]);
        chk("iq_pred_pc", bus.iq_pred_pc, h[31:0]);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; drives one cycle, checks the pre-edge view,
    // advances the model and returns at the next falling edge.
    task automatic cycle(input bit rdy, input bit clr, input logic [31:0] rpc,
                         input bit mr, input logic [31:0] res, input bit pop);
        rdy_in        = rdy;
        bus.RoB_clear = clr;
        bus.RoB_pc    = rpc;
        bus.i_m_ready = mr;
        bus.i_result  = res;
        bus.iq_pop    = pop;
        #1;
        check_model();
        model_step(rdy, clr, rpc, mr, res, pop);
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc  = 32'h0;
        m_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".i_waiting"}, 32'(bus.i_waiting), 32'd0);
        chk({tag, ".i_addr"}, bus.i_addr, 32'h0);
        chk({tag, ".iq_empty"}, 32'(bus.iq_empty), 32'd1);
        chk({tag, ".iq_inst"}, bus.iq_inst, 32'h0);
        chk({tag, ".iq_pc"}, bus.iq_pc, 32'h0);
        chk({tag, ".iq_pred_pc"}, bus.iq_pred_pc, 32'h0);
        chk({tag, ".state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        bit          rdy;
        bit          clr;
        logic [31:0] rpc;
        bit          mr;
        logic [31:0] res;
        bit          pop;
        bit          e_w;
        logic [31:0] e_addr;
        bit          e_empty;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic [31:0] e_pred;
    } vec_t;

    vec_t tbl[15];

    logic [31:0] r;
    logic [31:0] saved_pc;
    int          n_req;

    initial begin
        // rdy, clr, rpc, mr, res, pop | post-edge: waiting, addr, empty, inst, pc, pred
        tbl[0]  = '{1, 1, 32'h10,  0, NOP,  0,  0, 32'h10,  1, 32'h0, 32'h0,   32'h0};
        tbl[1]  = '{1, 0, 32'h0,   0, NOP,  0,  1, 32'h10,  1, 32'h0, 32'h0,   32'h0};
        tbl[2]  = '{1, 0, 32'h0,   1, JAL8, 0,  1, 32'h18,  0, JAL8,  32'h10,  32'h18};
        tbl[3]  = '{1, 1, 32'h20,  0, NOP,  0,  0, 32'h20,  1, 32'h0, 32'h0,   32'h0};
        tbl[4]  = '{1, 0, 32'h0,   0, NOP,  0,  1, 32'h20,  1, 32'h0, 32'h0,   32'h0};
        tbl[5]  = '{1, 0, 32'h0,   1, BEQM, 0,  1, 32'h1C,  0, BEQM,  32'h20,  32'h1C};
        tbl[6]  = '{1, 1, 32'h20,  0, NOP,  0,  0, 32'h20,  1, 32'h0, 32'h0,   32'h0};
        tbl[7]  = '{1, 0, 32'h0,   0, NOP,  0,  1, 32'h20,  1, 32'h0, 32'h0,   32'h0};
        tbl[8]  = '{1, 0, 32'h0,   1, BEQP, 0,  1, 32'h24,  0, BEQP,  32'h20,  32'h24};
        tbl[9]  = '{1, 0, 32'h0,   0, NOP,  1,  1, 32'h24,  1, 32'h0, 32'h0,   32'h0};
        tbl[10] = '{1, 0, 32'h0,   1, NOP,  0,  1, 32'h28,  0, NOP,   32'h24,  32'h28};
        tbl[11] = '{1, 1, 32'h100, 1, NOP,  1,  0, 32'h100, 1, 32'h0, 32'h0,   32'h0};
        tbl[12] = '{1, 0, 32'h0,   0, NOP,  0,  1, 32'h100, 1, 32'h0, 32'h0,   32'h0};
        tbl[13] = '{0, 1, 32'h200, 1, NOP,  1,  1, 32'h100, 1, 32'h0, 32'h0,   32'h0};
        tbl[14] = '{1, 0, 32'h0,   1, JALR, 0,  1, 32'h104, 0, JALR,  32'h100, 32'h104};

        // ---- reset ----
        rdy_in = 1'b1; bus.RoB_clear = 1'b0; bus.RoB_pc = '0;
        bus.i_m_ready = 1'b0; bus.i_result = NOP; bus.iq_pop = 1'b0;
        #1;
        check_reset_outputs("reset");
        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;

        // ---- fill from reset with a hit every cycle ----
        cycle(1, 0, 0, 1, NOP, 0);               // IDLE: response ignored
        for (int k = 0; k < 4; k++) begin
            chk("fill.addr", bus.i_addr, 32'(4 * k));
            cycle(1, 0, 0, 1, NOP, 0);
        end
        chk("fill.waiting_dropped", 32'(bus.i_waiting), 32'd0);
        chk("fill.not_empty", 32'(bus.iq_empty), 32'd0);
        chk("fill.head_pc", bus.iq_pc, 32'h0);
        cycle(1, 0, 0, 1, NOP, 0);               // full: no request

        // ---- single pop on a full queue -> exactly one request ----
        cycle(1, 0, 0, 0, NOP, 1);
        n_req = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.i_waiting === 1'b1) n_req++;
            cycle(1, 0, 0, 1, NOP, 0);
        end
        chk("one_request", 32'(n_req), 32'd1);

        // ---- pop + accept at count 3 keeps count 3 ----
        cycle(1, 0, 0, 0, NOP, 1);               // count 3, IDLE
        cycle(1, 0, 0, 0, NOP, 0);               // -> WAIT
        cycle(1, 0, 0, 1, NOP, 1);               // pop + accept
        chk("popacc.still_waiting", 32'(bus.i_waiting), 32'd1);
        cycle(1, 0, 0, 1, NOP, 0);               // count 4
        chk("popacc.full_after", 32'(bus.i_waiting), 32'd0);

        // ---- table vectors ----
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].rdy, tbl[i].clr, tbl[i].rpc, tbl[i].mr, tbl[i].res, tbl[i].pop);
            chk($sformatf("tbl%0d.waiting", i), 32'(bus.i_waiting), 32'(tbl[i].e_w));
            chk($sformatf("tbl%0d.addr", i), bus.i_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d.empty", i), 32'(bus.iq_empty), 32'(tbl[i].e_empty));
            chk($sformatf("tbl%0d.inst", i), bus.iq_inst, tbl[i].e_inst);
            chk($sformatf("tbl%0d.pc", i), bus.iq_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d.pred", i), bus.iq_pred_pc, tbl[i].e_pred);
        end

        // ---- rdy_in low for 5 cycles while responses, pops and clears arrive ----
        saved_pc = m_pc;
        for (int k = 0; k < 5; k++) cycle(0, k[0], 32'h300, 1, NOP, 1);
        chk("freeze.pc", bus.i_addr, saved_pc);
        chk("freeze.waiting", 32'(bus.i_waiting), 32'd1);
        chk("freeze.not_empty", 32'(bus.iq_empty), 32'd0);
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 1, NOP, 0);

        // ---- reset in the middle of a request ----
        cycle(1, 0, 0, 0, NOP, 1);
        cycle(1, 0, 0, 0, NOP, 0);
        #2 rst_in = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        cycle(1, 0, 0, 1, NOP, 0);               // stale response ignored
        chk("midreset.no_push", 32'(bus.iq_empty), 32'd1);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 1500; n++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0: r[6:0] = 7'h6F;
                1: r[6:0] = 7'h63;
                2: r[6:0] = 7'h67;
                default: ;
            endcase
            cycle($urandom_range(0, 9) != 0,
                  $urandom_range(0, 39) == 0,
                  {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                  $urandom_range(0, 9) < 6,
                  r,
                  $urandom_range(0, 9) < 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
